// File: rtl/display_sched.sv
// Scan and arbitration controller for a 4-digit seven-segment display.
// Picks one of three requesters, latches its message and multiplexes the BCD nibbles.
module display_sched #(
   parameter int SCAN_DIV    = 50000,
   parameter int HOLD_FRAMES = 200
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [2:0]  REQ,
   input  logic [15:0] DATA0,
   input  logic [15:0] DATA1,
   input  logic [15:0] DATA2,
   output logic [3:0]  CODE,
   output logic [3:0]  DIG_EN,
   output logic [1:0]  SRC,
   output logic [2:0]  ACK,
   output logic        BUSY
);

   // state | meaning
   // IDLE  | display blank, waiting for any request
   // SHOW  | scanning the latched message of source srcReg

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(HOLD_FRAMES - 1);
   localparam logic [1:0]    SRC_NONE   = 2'b11;

   typedef enum logic {IDLE, SHOW} stateT;

   stateT         state, stateNxt;
   logic [PW-1:0] preCnt, preNxt;
   logic [1:0]    digit, digitNxt;
   logic [FW-1:0] frameCnt, frameNxt;
   logic [15:0]   msg, msgNxt;
   logic [1:0]    srcReg, srcNxt;
   logic [2:0]    ackReg, ackNxt;

   logic [3:0]    reqExt;
   logic [1:0]    rrPtr;
   logic [1:0]    selSrc;
   logic          anyReq;
   logic          tick;
   logic          frameEnd;
   logic          withdraw;
   logic          preempt;
   logic          holdDone;

   // Alarm wins outright; otherwise the nearest active source after ptr, wrapping mod 3.
   function automatic logic [1:0] pickSource(input logic [2:0] req, input logic [1:0] ptr);
      logic [3:0] r;
      logic [1:0] cand;
      logic [1:0] result;
      int         c;
      r      = {1'b0, req};
      result = SRC_NONE;
      if (req[0]) begin
         result = 2'd0;
      end else begin
         for (int k = 3; k >= 1; k--) begin
            c    = (int'(ptr) + k) % 3;
            cand = 2'(c);
            if (r[cand]) result = cand;
         end
      end
      return result;
   endfunction

   function automatic logic [15:0] dataOf(input logic [1:0] s, input logic [15:0] d0,
                                          input logic [15:0] d1, input logic [15:0] d2);
      logic [15:0] d;
      case (s)
         2'd0:    d = d0;
         2'd1:    d = d1;
         2'd2:    d = d2;
         default: d = 16'h0000;
      endcase
      return d;
   endfunction

   assign reqExt   = {1'b0, REQ};
   assign anyReq   = |REQ;
   assign rrPtr    = (state == SHOW) ? srcReg : 2'd0;
   assign selSrc   = pickSource(REQ, rrPtr);
   assign tick     = (preCnt == PRE_LAST);
   assign frameEnd = tick && (digit == 2'd3);
   assign withdraw = !reqExt[srcReg];
   assign preempt  = REQ[0] && (srcReg != 2'd0);
   assign holdDone = (frameCnt == FRAME_LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         preCnt   <= '0;
         digit    <= 2'd0;
         frameCnt <= '0;
         msg      <= 16'h0000;
         srcReg   <= SRC_NONE;
         ackReg   <= 3'b000;
      end else begin
         state    <= stateNxt;
         preCnt   <= preNxt;
         digit    <= digitNxt;
         frameCnt <= frameNxt;
         msg      <= msgNxt;
         srcReg   <= srcNxt;
         ackReg   <= ackNxt;
      end
   end

   always_comb begin
      stateNxt = state;
      preNxt   = preCnt;
      digitNxt = digit;
      frameNxt = frameCnt;
      msgNxt   = msg;
      srcNxt   = srcReg;
      ackNxt   = 3'b000;
      case (state)
         IDLE: begin
            if (anyReq) begin
               stateNxt = SHOW;
               preNxt   = '0;
               digitNxt = 2'd0;
               frameNxt = '0;
               msgNxt   = dataOf(selSrc, DATA0, DATA1, DATA2);
               srcNxt   = selSrc;
            end
         end
         SHOW: begin
            preNxt = tick ? '0 : preCnt + PW'(1);
            if (tick) digitNxt = digit + 2'd1;
            if (frameEnd) begin
               if (withdraw || preempt || holdDone) begin
                  // Only a completed hold is acknowledged; withdrawal and preemption are silent.
                  if (!withdraw && !preempt) ackNxt = 3'b001 << srcReg;
                  frameNxt = '0;
                  if (anyReq) begin
                     msgNxt = dataOf(selSrc, DATA0, DATA1, DATA2);
                     srcNxt = selSrc;
                  end else begin
                     stateNxt = IDLE;
                     srcNxt   = SRC_NONE;
                  end
               end else begin
                  frameNxt = frameCnt + FW'(1);
               end
            end
         end
         default: stateNxt = IDLE;
      endcase
   end

   always_comb begin
      CODE   = 4'h0;
      DIG_EN = 4'b1111;
      if (state == SHOW) begin
         case (digit)
            2'd0:    CODE = msg[3:0];
            2'd1:    CODE = msg[7:4];
            2'd2:    CODE = msg[11:8];
            default: CODE = msg[15:12];
         endcase
         DIG_EN = ~(4'b0001 << digit);
      end
   end

   assign SRC  = srcReg;
   assign ACK  = ackReg;
   assign BUSY = (state == SHOW);

endmodule

// File: tb/tb_display_sched.sv
// Bench for display_sched: directed scenarios with literal expectations plus a randomized
// run, all checked every cycle against an elapsed-time model of the scheduler.
module tb_display_sched;

   localparam int SD    = 4;
   localparam int HF    = 2;
   localparam int FRAME = 4 * SD;
   localparam int HOLD  = FRAME * HF;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [2:0]  REQ = 3'b000;
   logic [15:0] DATA0 = 16'h0000;
   logic [15:0] DATA1 = 16'h0000;
   logic [15:0] DATA2 = 16'h0000;
   logic [3:0]  CODE;
   logic [3:0]  DIG_EN;
   logic [1:0]  SRC;
   logic [2:0]  ACK;
   logic        BUSY;

   int checks = 0;
   int failures = 0;

   display_sched #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
      .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
      .DATA0(DATA0), .DATA1(DATA1), .DATA2(DATA2),
      .CODE(CODE), .DIG_EN(DIG_EN), .SRC(SRC), .ACK(ACK), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   // Model: which source is on screen and how many cycles since it was selected.
   typedef struct packed {
      logic        show;
      logic [1:0]  src;
      logic [15:0] msg;
      logic [2:0]  ack;
      logic [31:0] elapsed;
   } modelT;

   modelT mdl;

   function automatic logic [1:0] rrPick(input logic [2:0] req, input int after);
      int c;
      if (req[0]) return 2'd0;
      for (int k = 1; k <= 3; k++) begin
         c = (after + k) % 3;
         if (req[c]) return 2'(c);
      end
      return 2'd3;
   endfunction

   function automatic logic [15:0] pickData(input logic [1:0] s, input logic [15:0] d0,
                                            input logic [15:0] d1, input logic [15:0] d2);
      if (s == 2'd0) return d0;
      if (s == 2'd1) return d1;
      return d2;
   endfunction

   function automatic modelT step(input modelT m, input logic [2:0] req, input logic [15:0] d0,
                                  input logic [15:0] d1, input logic [15:0] d2);
      modelT n;
      int    cur;
      int    nextElapsed;
      logic  stillWanted;
      logic  alarmCut;
      n     = m;
      n.ack = 3'b000;
      cur   = int'(m.src);
      nextElapsed = int'(m.elapsed) + 1;
      if (!m.show) begin
         if (req != 3'b000) begin
            n.show    = 1'b1;
            n.src     = rrPick(req, 0);
            n.msg     = pickData(n.src, d0, d1, d2);
            n.elapsed = 0;
         end
      end else if (nextElapsed % FRAME != 0) begin
         n.elapsed = 32'(nextElapsed);
      end else begin
         stillWanted = req[cur];
         alarmCut    = req[0] && (cur != 0);
         if (stillWanted && !alarmCut && nextElapsed < HOLD) begin
            n.elapsed = 32'(nextElapsed);
         end else begin
            if (stillWanted && !alarmCut) n.ack = 3'(1 << cur);
            n.elapsed = 0;
            if (req != 3'b000) begin
               n.src = rrPick(req, cur);
               n.msg = pickData(n.src, d0, d1, d2);
            end else begin
               n.show = 1'b0;
               n.src  = 2'd3;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [3:0] expCode(input modelT m);
      logic [15:0] sh;
      int          dig;
      if (!m.show) return 4'h0;
      dig = (int'(m.elapsed) / SD) % 4;
      sh  = m.msg >> (4 * dig);
      return sh[3:0];
   endfunction

   function automatic logic [3:0] expEn(input modelT m);
      int dig;
      if (!m.show) return 4'b1111;
      dig = (int'(m.elapsed) / SD) % 4;
      return ~(4'(1 << dig));
   endfunction

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) mdl <= '{show: 1'b0, src: 2'd3, msg: 16'h0, ack: 3'b000, elapsed: 32'd0};
      else        mdl <= step(mdl, REQ, DATA0, DATA1, DATA2);
   end

   logic [3:0] eCode;
   logic [3:0] eEn;

   always @(negedge CLK) begin
      eCode = expCode(mdl);
      eEn   = expEn(mdl);
      checks++;
      if (CODE !== eCode || DIG_EN !== eEn || SRC !== mdl.src || ACK !== mdl.ack || BUSY !== mdl.show) begin
         failures++;
         $display("FAIL model_cmp t=%0t got code=%h en=%b src=%0d ack=%b busy=%b want code=%h en=%b src=%0d ack=%b busy=%b",
                  $time, CODE, DIG_EN, SRC, ACK, BUSY, eCode, eEn, mdl.src, mdl.ack, mdl.show);
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
      end
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (BUSY && n < 40) begin
         @(negedge CLK);
         n++;
      end
      chk("reach_idle", 16'(BUSY), 16'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset and idle
      RST_N = 1'b0;
      REQ   = 3'b000;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (10) begin
         @(negedge CLK);
         chk("idle_digen", 16'(DIG_EN), 16'hF);
         chk("idle_src", 16'(SRC), 16'h3);
         chk("idle_busy", 16'(BUSY), 16'h0);
         chk("idle_ack", 16'(ACK), 16'h0);
      end

      // 2: single source, data change mid-hold only shows at reselection
      DATA0 = 16'h4321;
      DATA1 = 16'hA5B6;
      DATA2 = 16'h789C;
      REQ   = 3'b001;
      for (int c = 0; c < 34; c++) begin
         @(negedge CLK);
         case (c)
            0:  begin chk("s_code0", 16'(CODE), 16'h1); chk("s_en0", 16'(DIG_EN), 16'hE); chk("s_busy", 16'(BUSY), 16'h1); end
            4:  begin chk("s_code1", 16'(CODE), 16'h2); chk("s_en1", 16'(DIG_EN), 16'hD); end
            8:  begin chk("s_code2", 16'(CODE), 16'h3); chk("s_en2", 16'(DIG_EN), 16'hB); end
            12: begin chk("s_code3", 16'(CODE), 16'h4); chk("s_en3", 16'(DIG_EN), 16'h7); end
            31: begin chk("s_ack_early", 16'(ACK), 16'h0); chk("s_code_last", 16'(CODE), 16'h4); end
            32: begin chk("s_ack", 16'(ACK), 16'h1); chk("s_code_new", 16'(CODE), 16'h5); chk("s_en_new", 16'(DIG_EN), 16'hE); end
            33: chk("s_ack_once", 16'(ACK), 16'h0);
            default: ;
         endcase
         if (c == 2) DATA0 = 16'h8765;
      end
      REQ = 3'b000;
      waitIdle();

      // 3: round-robin between mode and tank level
      REQ = 3'b110;
      for (int c = 0; c < 97; c++) begin
         @(negedge CLK);
         case (c)
            0:  begin chk("rr_src0", 16'(SRC), 16'h1); chk("rr_code0", 16'(CODE), 16'h6); end
            31: chk("rr_src31", 16'(SRC), 16'h1);
            32: begin chk("rr_src32", 16'(SRC), 16'h2); chk("rr_ack32", 16'(ACK), 16'h2); chk("rr_code32", 16'(CODE), 16'hC); end
            63: chk("rr_ack63", 16'(ACK), 16'h0);
            64: begin chk("rr_src64", 16'(SRC), 16'h1); chk("rr_ack64", 16'(ACK), 16'h4); end
            96: begin chk("rr_src96", 16'(SRC), 16'h2); chk("rr_ack96", 16'(ACK), 16'h2); end
            default: ;
         endcase
      end
      REQ = 3'b000;
      waitIdle();

      // 4: alarm preempts tank level at a frame end, tank level then gets a full hold
      REQ = 3'b100;
      for (int c = 0; c < 65; c++) begin
         @(negedge CLK);
         case (c)
            15: chk("pre_src15", 16'(SRC), 16'h2);
            16: begin chk("pre_src16", 16'(SRC), 16'h0); chk("pre_ack16", 16'(ACK), 16'h0); chk("pre_code16", 16'(CODE), 16'h5); end
            31: chk("pre_src31", 16'(SRC), 16'h0);
            32: begin chk("pre_src32", 16'(SRC), 16'h2); chk("pre_ack32", 16'(ACK), 16'h0); end
            63: chk("pre_ack63", 16'(ACK), 16'h0);
            64: begin chk("pre_ack64", 16'(ACK), 16'h4); chk("pre_src64", 16'(SRC), 16'h2); end
            default: ;
         endcase
         if (c == 5)  REQ = 3'b101;
         if (c == 20) REQ = 3'b100;
      end
      REQ = 3'b000;
      waitIdle();

      // 5: withdrawal of the only source returns to idle without ACK
      REQ = 3'b010;
      for (int c = 0; c < 18; c++) begin
         @(negedge CLK);
         case (c)
            15: begin chk("wd_busy15", 16'(BUSY), 16'h1); chk("wd_src15", 16'(SRC), 16'h1); end
            16: begin
               chk("wd_busy16", 16'(BUSY), 16'h0);
               chk("wd_en16", 16'(DIG_EN), 16'hF);
               chk("wd_ack16", 16'(ACK), 16'h0);
               chk("wd_src16", 16'(SRC), 16'h3);
            end
            17: chk("wd_ack17", 16'(ACK), 16'h0);
            default: ;
         endcase
         if (c == 6) REQ = 3'b000;
      end

      // 6: asynchronous reset between clock edges
      REQ = 3'b001;
      repeat (6) @(negedge CLK);
      @(posedge CLK);
      #2;
      chk("ar_busy_before", 16'(BUSY), 16'h1);
      RST_N = 1'b0;
      #1;
      chk("ar_en", 16'(DIG_EN), 16'hF);
      chk("ar_code", 16'(CODE), 16'h0);
      chk("ar_src", 16'(SRC), 16'h3);
      chk("ar_busy", 16'(BUSY), 16'h0);
      REQ = 3'b000;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (4) @(negedge CLK);

      // randomized traffic, checked by the compare process
      for (int i = 0; i < 4000; i++) begin
         @(negedge CLK);
         if ($urandom_range(0, 19) == 0) REQ = 3'($urandom_range(0, 7));
         DATA0 = 16'($urandom);
         DATA1 = 16'($urandom);
         DATA2 = 16'($urandom);
         if ($urandom_range(0, 1499) == 0) begin
            RST_N = 1'b0;
            @(negedge CLK);
            RST_N = 1'b1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
